flanger_sweep_ctrl: RTL
=======================

# flanger_sweep_ctrl

Sweep controller for the `flanger` effect datapath. It takes a per-sample strobe from the audio codec path and produces the flanger's `clk_enable` and its 6-bit `delay` input. The delay sweeps as a triangle LFO between a programmable minimum and maximum, at a programmable rate. It sits between the sample-rate strobe source and the `flanger` instance, and is configured through a valid/ready register interface.

## Interface
- `DELAY_W`, 6: width of the delay output; must match the flanger `delay` port.
- `RATE_W`, 16: width of the rate divider (samples per delay step).
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `sample_en` input 1: one-cycle strobe, one per audio sample.
- `cfg_valid` input 1: configuration request.
- `cfg_rate` input RATE_W: samples per one-step delay change; 0 stops the sweep.
- `cfg_min` input DELAY_W: lower sweep bound.
- `cfg_max` input DELAY_W: upper sweep bound.
- `cfg_ready` output 1: configuration can be accepted.
- `cfg_err` output 1: one-cycle pulse when a request is rejected.
- `fx_enable` output 1: `clk_enable` for the flanger.
- `delay` output DELAY_W: delay value for the flanger.
- `delay_valid` output 1: one-cycle pulse when `delay` changes value.
- `sweep_dir` output 1: 0 while in RISE or IDLE, 1 while in FALL.

## Operation
- **Registers:** `rate_q`, `min_q`, `max_q`, divider `div_q` (RATE_W bits), `delay`, and a state register.
- **States:**
  - IDLE: no sweeping; `delay` holds.
  - RISE: delay steps +1.
  - FALL: delay steps −1.
- **Handshake:** a request is accepted when `cfg_valid && cfg_ready`.
  - `cfg_ready` drops for exactly the one cycle after any accepted request, including a rejected one. It is high otherwise.
- **Valid accept** (`cfg_min <= cfg_max`):
  - Latch `rate_q`/`min_q`/`max_q`.
  - `div_q <= 0`.
  - `delay <= cfg_min`.
  - `delay_valid` pulses if the value changed.
  - State becomes IDLE if `cfg_rate == 0`, else RISE.
- **Rejected accept** (`cfg_min > cfg_max`): `cfg_err` pulses; no state or register changes.
- **Divider:** counts `sample_en` only in RISE/FALL.
  - If `div_q == rate_q-1`: set `div_q <= 0` and issue a step.
  - Otherwise: `div_q <= div_q+1`.
  - Compare at full RATE_W width.
- **Step in RISE:**
  - If `delay < max_q`: `delay <= delay+1`. If the new value equals `max_q`, go to FALL.
  - If `delay == max_q` (only possible when min == max): no change, no `delay_valid`.
- **Step in FALL:**
  - `delay <= delay-1`.
  - If the new value equals `min_q`, go to RISE.
- **Degenerate min == max:** remain in RISE; `delay` constant; `delay_valid` never pulses.
- **No wrap-around:** `delay` never leaves [`min_q`, `max_q`].
- **Collision:** accept and `sample_en` in the same cycle → configuration wins; that sample's divider/step is dropped. `fx_enable` is still generated for that sample.
- **`fx_enable`:** `sample_en` registered by one cycle, in all states including IDLE. The flanger therefore samples the updated `delay`.

## Timing
- **Reset values:**
  - State IDLE, `delay` = 0, `div_q` = 0, `rate_q` = 0, `min_q` = 0, `max_q` = 0.
  - `fx_enable` = 0, `delay_valid` = 0, `cfg_err` = 0, `sweep_dir` = 0, `cfg_ready` = 1.
- **Reset mid-sweep:** asynchronous return to the values above; the configuration is lost.
- **`sample_en` high in cycle t:**
  - Step result on `delay` from t+1.
  - `fx_enable` = 1 in t+1.
  - `delay_valid` = 1 in t+1 (if the value changed).
- **Config accepted in cycle t:**
  - New `delay`, state and `sweep_dir` visible from t+1.
  - `cfg_ready` = 0 in t+1, 1 again in t+2.
  - `cfg_err` (on reject) high in t+1 only.
- **Back-to-back strobes:** a `sample_en` on consecutive cycles is legal; each is processed.
- **Output timing:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-sweep → all outputs at reset values asynchronously; `fx_enable` resumes one cycle after the first `sample_en` following release.
- **Triangle sweep:** cfg rate=2, min=3, max=5, then 12 `sample_en` strobes → `delay` after each strobe: 3,4,4,5,5,4,4,3,3,4,4,5. `sweep_dir` = 1 from the strobe that reaches 5 until the one that reaches 3.
- **Rejected config:** cfg min=10, max=4 during a sweep → `cfg_err` one cycle; `cfg_ready` low one cycle; sweep continues unchanged.
- **Stop:** cfg rate=0, min=7, max=20 → `delay` = 7, IDLE; 100 strobes give 100 `fx_enable` pulses with no `delay` change and no `delay_valid`.
- **Collision:** cfg accepted in the same cycle as a stepping `sample_en` → `delay` = new min, `div_q` = 0, `fx_enable` still pulses next cycle.
- **Bounds:** cfg rate=1, min=0, max=63 → reaches 63 after 63 strobes, then descends; never wraps; min==max=9 → constant 9 with no `delay_valid`.

Source files
------------

// File: rtl/flanger_sweep_ctrl_if.sv
// Configuration request channel for flanger_sweep_ctrl.
// The valid/ready handshake carries the sweep rate and delay bounds; cfg_err answers a rejected request.
interface flanger_sweep_ctrl_if #(
  parameter int DELAY_W = 6,
  parameter int RATE_W  = 16
);
  logic               cfg_valid;
  logic [RATE_W-1:0]  cfg_rate;
  logic [DELAY_W-1:0] cfg_min;
  logic [DELAY_W-1:0] cfg_max;
  logic               cfg_ready;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_rate, cfg_min, cfg_max,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_rate, cfg_min, cfg_max,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/flanger_sweep_ctrl.sv
// Triangle-LFO sweep of the flanger delay between programmable bounds.
// It also produces the flanger clk_enable from the per-sample strobe.
module flanger_sweep_ctrl #(
  parameter int DELAY_W = 6,
  parameter int RATE_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_en,
  flanger_sweep_ctrl_if.slave cfg,
  output logic               fx_enable,
  output logic [DELAY_W-1:0] delay,
  output logic               delay_valid,
  output logic               sweep_dir
);

  typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

  typedef struct packed {
    logic [RATE_W-1:0]  rate;
    logic [DELAY_W-1:0] lo;
    logic [DELAY_W-1:0] hi;
  } sweep_cfg_t;

  localparam logic [DELAY_W-1:0] D_ONE = DELAY_W'(1);
  localparam logic [RATE_W-1:0]  R_ONE = RATE_W'(1);

  state_t             state_q, state_d;
  sweep_cfg_t         cfg_q;
  logic [RATE_W-1:0]  div_q;

  logic               accept, cfg_ok, step, rise_room;
  logic [DELAY_W-1:0] delay_inc, delay_dec;

  always_comb begin
    accept    = cfg.cfg_valid && cfg.cfg_ready;
    cfg_ok    = cfg.cfg_min <= cfg.cfg_max;
    delay_inc = delay + D_ONE;
    delay_dec = delay - D_ONE;
    rise_room = delay < cfg_q.hi;
    // An accepted request in the same cycle as a strobe swallows that strobe's step.
    step      = sample_en && !accept && (state_q != IDLE) &&
                (div_q == (cfg_q.rate - R_ONE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept && cfg_ok) begin
      state_d = (cfg.cfg_rate == '0) ? IDLE : RISE;
    end else if (step) begin
      case (state_q)
        RISE:    if (rise_room && (delay_inc == cfg_q.hi)) state_d = FALL;
        FALL:    if (delay_dec == cfg_q.lo) state_d = RISE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sweep_dir = (state_q == FALL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q         <= '0;
      div_q         <= '0;
      delay         <= '0;
      delay_valid   <= 1'b0;
      fx_enable     <= 1'b0;
      cfg.cfg_ready <= 1'b1;
      cfg.cfg_err   <= 1'b0;
    end else begin
      fx_enable     <= sample_en;
      cfg.cfg_ready <= !accept;
      cfg.cfg_err   <= accept && !cfg_ok;
      delay_valid   <= 1'b0;
      if (accept) begin
        if (cfg_ok) begin
          cfg_q       <= '{rate: cfg.cfg_rate, lo: cfg.cfg_min, hi: cfg.cfg_max};
          div_q       <= '0;
          delay       <= cfg.cfg_min;
          delay_valid <= (cfg.cfg_min != delay);
        end
      end else if (sample_en && (state_q != IDLE)) begin
        if (step) begin
          div_q <= '0;
          if (state_q == RISE) begin
            if (rise_room) begin
              delay       <= delay_inc;
              delay_valid <= 1'b1;
            end
          end else begin
            delay       <= delay_dec;
            delay_valid <= 1'b1;
          end
        end else begin
          div_q <= div_q + R_ONE;
        end
      end
    end
  end

endmodule
